// File: rtl/muldiv_sequencer.sv
// EX-stage sequencer for iterative MULTU/DIVU with a one-cycle HiLo write.
// Optional stall-cycle counter: define MULDIV_STALL_COUNT_EN.
module muldiv_sequencer #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned DIV_CYCLES = 33,
  parameter logic [5:0]  OP_MULTU   = 6'b011001,
  parameter logic [5:0]  OP_DIVU    = 6'b011011,
  parameter logic [5:0]  OP_HILO_WR = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [5:0]  op_code,
  input  logic        flush,
  output logic [5:0]  alu_ctrl,
  output logic        hilo_we,
  output logic        stall,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  localparam logic [6:0] MUL_LIM = 7'(MUL_CYCLES);
  localparam logic [6:0] DIV_LIM = 7'(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] lim_q, lim_d;
  logic [5:0] op_q, op_d;
  logic [5:0] alu_q, alu_d;
  logic       hilo_q, hilo_d;
  logic       busy_q, busy_d;
  logic       is_md, start, last;

  assign is_md = (op_code == OP_MULTU) ||
                 (op_code == OP_DIVU);
  assign start = op_valid && is_md && !flush;
  assign last  = (cnt_q == lim_q - 7'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      op_q    <= '0;
      alu_q   <= '0;
      hilo_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
      hilo_q  <= hilo_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    op_d    = op_q;
    alu_d   = alu_q;
    hilo_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        alu_d = (op_valid && !flush) ? op_code : '0;
        if (start) begin
          op_d    = op_code;
          lim_d   = (op_code == OP_DIVU) ? DIV_LIM : MUL_LIM;
          state_d = RUN;
        end
      end
      RUN: begin
        // flush beats the final iteration: no HiLo write
        if (flush) begin
          state_d = IDLE;
          alu_d   = '0;
          cnt_d   = '0;
        end else if (last) begin
          state_d = WRITE;
          alu_d   = OP_HILO_WR;
          hilo_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          alu_d = op_q;
          cnt_d = cnt_q + 7'd1;
        end
      end
      WRITE: begin
        state_d = IDLE;
        alu_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        alu_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      IDLE:    stall = start;
      RUN:     stall = 1'b1;
      WRITE:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign alu_ctrl = alu_q;
  assign hilo_we  = hilo_q;
  assign busy     = busy_q;

`ifdef MULDIV_STALL_COUNT_EN
  logic [31:0] sc_q, sc_d;

  always_comb sc_d = stall ? sc_q + 32'd1 : sc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sc_q <= '0;
    else        sc_q <= sc_d;
  end

  assign stall_cycles = sc_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: pass-through, MULTU/DIVU runs,
// back-to-back issue, flush abort, reset mid-run, stall counter.
module tb_muldiv_sequencer;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] HILO  = 6'b111111;
  localparam logic [5:0] ADDOP = 6'b100000;

`ifdef MULDIV_STALL_COUNT_EN
  localparam logic [31:0] SC_DIV = 32'd35;
`else
  localparam logic [31:0] SC_DIV = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [5:0]  op_code = '0;
  logic        flush = 1'b0;
  logic [5:0]  alu_ctrl;
  logic        hilo_we;
  logic        stall;
  logic        busy;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad = 0;

  muldiv_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .flush        (flush),
    .alu_ctrl     (alu_ctrl),
    .hilo_we      (hilo_we),
    .stall        (stall),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op_valid = 1'b1;
    op_code = ADDOP;
    tick();
    tick();
    total++;
    if (alu_ctrl !== 6'd0) begin
      bad++;
      $display("FAIL rst_alu got=%h exp=00", alu_ctrl);
    end
    total++;
    if ({hilo_we, busy, stall} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=000", {hilo_we, busy, stall});
    end
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL rst_sc got=%0d exp=0", stall_cycles);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (alu_ctrl !== ADDOP) begin
      bad++;
      $display("FAIL pass_alu got=%h exp=%h", alu_ctrl, ADDOP);
    end
    total++;
    if ({hilo_we, stall, busy} !== 3'b000) begin
      bad++;
      $display("FAIL pass_flags got=%b exp=000", {hilo_we, stall, busy});
    end
    op_valid = 1'b0;
    tick();
    total++;
    if (alu_ctrl !== 6'd0) begin
      bad++;
      $display("FAIL pass_clear got=%h exp=00", alu_ctrl);
    end
  endtask

  task automatic test_divu();
    int n;
    bit err;
    op_valid = 1'b1;
    op_code = DIVU;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL div_accept_stall got=%b exp=1", stall);
    end
    tick();
    op_valid = 1'b0;
    n = 0;
    err = 1'b0;
    while (alu_ctrl === DIVU && n < 100) begin
      if (stall !== 1'b1 || busy !== 1'b1 || hilo_we !== 1'b0) err = 1'b1;
      n++;
      tick();
    end
    total++;
    if (n != 33 || err) begin
      bad++;
      $display("FAIL div_run got=%0d err=%b exp=33 err=0", n, err);
    end
    total++;
    if ({alu_ctrl, hilo_we, stall, busy} !== {HILO, 3'b111}) begin
      bad++;
      $display("FAIL div_write got=%h/%b%b%b exp=3f/111",
               alu_ctrl, hilo_we, stall, busy);
    end
    tick();
    total++;
    if ({alu_ctrl, hilo_we, stall, busy} !== {6'd0, 3'b000}) begin
      bad++;
      $display("FAIL div_idle got=%h/%b%b%b exp=00/000",
               alu_ctrl, hilo_we, stall, busy);
    end
    total++;
    if (stall_cycles !== SC_DIV) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=%0d", stall_cycles, SC_DIV);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit err;
    op_valid = 1'b1;
    op_code = MULTU;
    tick();
    op_valid = 1'b0;
    n = 0;
    err = 1'b0;
    while (alu_ctrl === MULTU && n < 100) begin
      if (hilo_we !== 1'b0 || stall !== 1'b1) err = 1'b1;
      n++;
      tick();
    end
    total++;
    if (n != 32 || err) begin
      bad++;
      $display("FAIL b2b_mul_run got=%0d err=%b exp=32 err=0", n, err);
    end
    total++;
    if ({alu_ctrl, hilo_we} !== {HILO, 1'b1}) begin
      bad++;
      $display("FAIL b2b_write1 got=%h/%b exp=3f/1", alu_ctrl, hilo_we);
    end
    op_valid = 1'b1;
    op_code = DIVU;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL b2b_hold_stall got=%b exp=1", stall);
    end
    tick();
    total++;
    if ({alu_ctrl, hilo_we, busy, stall} !== {6'd0, 3'b001}) begin
      bad++;
      $display("FAIL b2b_idle got=%h/%b%b%b exp=00/001",
               alu_ctrl, hilo_we, busy, stall);
    end
    tick();
    op_valid = 1'b0;
    n = 0;
    err = 1'b0;
    while (alu_ctrl === DIVU && n < 100) begin
      if (hilo_we !== 1'b0) err = 1'b1;
      n++;
      tick();
    end
    total++;
    if (n != 33 || err) begin
      bad++;
      $display("FAIL b2b_div_run got=%0d err=%b exp=33 err=0", n, err);
    end
    total++;
    if ({alu_ctrl, hilo_we} !== {HILO, 1'b1}) begin
      bad++;
      $display("FAIL b2b_write2 got=%h/%b exp=3f/1", alu_ctrl, hilo_we);
    end
    tick();
    total++;
    if ({hilo_we, busy, stall} !== 3'b000) begin
      bad++;
      $display("FAIL b2b_end got=%b exp=000", {hilo_we, busy, stall});
    end
  endtask

  task automatic test_abort();
    bit err;
    for (int k = 0; k < 2; k++) begin
      op_valid = 1'b1;
      op_code = DIVU;
      tick();
      op_valid = 1'b0;
      // k=0: flush at cnt==9, k=1: flush on the final RUN edge (cnt==32)
      for (int i = 0; i < (k == 0 ? 9 : 32); i++) tick();
      total++;
      if ({alu_ctrl, busy, stall} !== {DIVU, 2'b11}) begin
        bad++;
        $display("FAIL abort%0d_pre got=%h/%b%b exp=1b/11",
                 k, alu_ctrl, busy, stall);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      total++;
      if ({alu_ctrl, hilo_we, busy, stall} !== {6'd0, 3'b000}) begin
        bad++;
        $display("FAIL abort%0d_idle got=%h/%b%b%b exp=00/000",
                 k, alu_ctrl, hilo_we, busy, stall);
      end
      err = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (hilo_we !== 1'b0 || busy !== 1'b0) err = 1'b1;
      end
      total++;
      if (err) begin
        bad++;
        $display("FAIL abort%0d_quiet got=err exp=no hilo_we/busy", k);
      end
    end
    op_valid = 1'b1;
    op_code = DIVU;
    flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL idle_flush_stall got=%b exp=0", stall);
    end
    tick();
    op_valid = 1'b0;
    flush = 1'b0;
    total++;
    if ({alu_ctrl, busy} !== {6'd0, 1'b0}) begin
      bad++;
      $display("FAIL idle_flush got=%h/%b exp=00/0", alu_ctrl, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit err;
    op_valid = 1'b1;
    op_code = MULTU;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    total++;
    if ({alu_ctrl, hilo_we, busy, stall} !== {6'd0, 3'b000}) begin
      bad++;
      $display("FAIL midrst got=%h/%b%b%b exp=00/000",
               alu_ctrl, hilo_we, busy, stall);
    end
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL midrst_sc got=%0d exp=0", stall_cycles);
    end
    rst_n = 1'b1;
    err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hilo_we !== 1'b0 || busy !== 1'b0) err = 1'b1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL midrst_quiet got=err exp=no hilo_we/busy");
    end
    op_valid = 1'b1;
    op_code = MULTU;
    tick();
    op_valid = 1'b0;
    n = 0;
    while (alu_ctrl === MULTU && n < 100) begin
      n++;
      tick();
    end
    total++;
    if (n != 32 || {alu_ctrl, hilo_we} !== {HILO, 1'b1}) begin
      bad++;
      $display("FAIL midrst_rerun got=%0d/%h exp=32/3f", n, alu_ctrl);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_divu();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
